// File: rtl/spi_temp_reader_if.sv
// rtl/spi_temp_reader_if.sv - request/sample handshake and SPI pins of the temperature reader
interface spi_temp_reader_if;
  logic        start;
  logic        spi_miso;
  logic        spi_sclk;
  logic        spi_cs_n;
  logic        busy;
  logic        temp_valid;
  logic [12:0] temp_data;
  logic        sensor_fault;

  modport master (
    input  start, spi_miso,
    output spi_sclk, spi_cs_n, busy, temp_valid, temp_data, sensor_fault
  );

  modport slave (
    output start, spi_miso,
    input  spi_sclk, spi_cs_n, busy, temp_valid, temp_data, sensor_fault
  );
endinterface

// File: rtl/spi_temp_reader.sv
// rtl/spi_temp_reader.sv - SPI mode-0 master reading one 16-bit temperature frame per request
// Optional periodic auto-trigger is enabled by defining SAMPLE_TIMER_EN.
module spi_temp_reader #(
  parameter int CLK_DIV = 5,
  parameter int CS_GAP  = 2
`ifdef SAMPLE_TIMER_EN
  ,
  parameter int SAMPLE_PERIOD = 10_000_000
`endif
) (
  input logic clk,
  input logic rst,
  spi_temp_reader_if.master bus
);

  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    bit_idx, bit_idx_n;
  logic          sclk_q, sclk_n;
  logic          cs_n_q, cs_n_n;
  logic          busy_q, busy_n;
  logic          valid_q, valid_n;
  logic [15:0]   shreg, shreg_n;
  logic [12:0]   data_q, data_n;
  logic          fault_q, fault_n;
  logic          start_eff;

`ifdef SAMPLE_TIMER_EN
  localparam int TW = $clog2(SAMPLE_PERIOD);
  logic [TW-1:0] tmr;
  logic          tick;

  assign tick      = (tmr == TW'(SAMPLE_PERIOD - 1));
  assign start_eff = bus.start | tick;

  always_ff @(posedge clk) begin
    if (rst) tmr <= '0;
    else     tmr <= tick ? '0 : tmr + TW'(1);
  end
`else
  assign start_eff = bus.start;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      shreg   <= '0;
      data_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      sclk_q  <= sclk_n;
      cs_n_q  <= cs_n_n;
      busy_q  <= busy_n;
      valid_q <= valid_n;
      shreg   <= shreg_n;
      data_q  <= data_n;
      fault_q <= fault_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    sclk_n    = sclk_q;
    cs_n_n    = cs_n_q;
    busy_n    = busy_q;
    valid_n   = 1'b0;
    shreg_n   = shreg;
    data_n    = data_q;
    fault_n   = fault_q;
    case (state)
      IDLE: begin
        // The cycle carrying the valid pulse never accepts a request.
        if (start_eff && !valid_q) begin
          state_n = SETUP;
          cs_n_n  = 1'b0;
          busy_n  = 1'b1;
          cnt_n   = '0;
        end
      end
      SETUP: begin
        if (cnt == CW'(CS_GAP - 1)) begin
          state_n   = SHIFT;
          cnt_n     = '0;
          bit_idx_n = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      SHIFT: begin
        if (cnt == CW'(CLK_DIV - 1)) begin
          cnt_n = '0;
          if (!sclk_q) begin
            // Sample on the edge that raises sclk; miso has been stable a full half-period.
            sclk_n  = 1'b1;
            shreg_n = {shreg[14:0], bus.spi_miso};
          end else begin
            sclk_n = 1'b0;
            if (bit_idx == 4'd15) state_n = HOLD;
            else                  bit_idx_n = bit_idx + 4'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      HOLD: begin
        if (cnt == CW'(CS_GAP - 1)) begin
          state_n = IDLE;
          cnt_n   = '0;
          cs_n_n  = 1'b1;
          busy_n  = 1'b0;
          valid_n = 1'b1;
          if (shreg == 16'hFFFF || shreg == 16'h0000) begin
            fault_n = 1'b1;
          end else begin
            fault_n = 1'b0;
            data_n  = shreg[15:3];
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.spi_sclk     = sclk_q;
  assign bus.spi_cs_n     = cs_n_q;
  assign bus.busy         = busy_q;
  assign bus.temp_valid   = valid_q;
  assign bus.temp_data    = data_q;
  assign bus.sensor_fault = fault_q;

endmodule

// File: tb/tb_spi_temp_reader.sv
// tb/tb_spi_temp_reader.sv - directed vector bench for spi_temp_reader with a mode-0 sensor model
module tb_spi_temp_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] sensor_word = 16'h0C80;
  int checks = 0;
  int errors = 0;

  spi_temp_reader_if bus();

`ifdef SAMPLE_TIMER_EN
  spi_temp_reader #(.CLK_DIV(5), .CS_GAP(2), .SAMPLE_PERIOD(1000)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  spi_temp_reader #(.CLK_DIV(5), .CS_GAP(2)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  // Sensor: presents MSB when selected, advances one bit on each falling sclk.
  int   sidx = 15;
  logic prev_sclk_m = 1'b0;
  always @(negedge clk) begin
    if (bus.spi_cs_n) sidx = 15;
    else if (prev_sclk_m && !bus.spi_sclk && sidx > 0) sidx = sidx - 1;
    prev_sclk_m = bus.spi_sclk;
    bus.spi_miso = sensor_word[sidx[3:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_read(output int lat);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.temp_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    logic [15:0] frame;
    logic [12:0] exp_data;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat;
    int frames, pulses, rises, r1, r2, f1, f2, n;
    logic pcs, psclk;

    vecs[0] = '{16'h0C80, 13'h0190, 1'b0};
    vecs[1] = '{16'hE700, 13'h1CE0, 1'b0};
    vecs[2] = '{16'hFFFF, 13'h1CE0, 1'b1};
    vecs[3] = '{16'h0000, 13'h1CE0, 1'b1};
    vecs[4] = '{16'h1237, 13'h0246, 1'b0};
    vecs[5] = '{16'h8000, 13'h1000, 1'b0};
    vecs[6] = '{16'hFFF8, 13'h1FFF, 1'b0};
    vecs[7] = '{16'h0007, 13'h0000, 1'b0};

    bus.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset sclk", {31'd0, bus.spi_sclk}, 32'd0);
    check("reset cs_n", {31'd0, bus.spi_cs_n}, 32'd1);
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset valid", {31'd0, bus.temp_valid}, 32'd0);
    check("reset data", {19'd0, bus.temp_data}, 32'd0);
    check("reset fault", {31'd0, bus.sensor_fault}, 32'd0);

`ifdef SAMPLE_TIMER_EN
    pulses = 0; f1 = -1; r1 = -1; pcs = 1'b1;
    for (int i = 1; i <= 5200; i++) begin
      @(negedge clk);
      if (pcs && !bus.spi_cs_n && f1 < 0) f1 = i;
      if (bus.temp_valid) begin
        pulses++;
        if (r1 < 0) r1 = i;
      end
      pcs = bus.spi_cs_n;
    end
    check("timer reads", pulses, 5);
    check("timer first cs", f1, 1000);
    check("timer latency", r1 - f1, 164);
`else
    // Reset 60 cycles into a frame discards it without a valid pulse.
    sensor_word = 16'h0C80;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (59) @(negedge clk);
    check("midframe busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort cs_n", {31'd0, bus.spi_cs_n}, 32'd1);
    check("abort sclk", {31'd0, bus.spi_sclk}, 32'd0);
    check("abort busy", {31'd0, bus.busy}, 32'd0);
    check("abort valid", {31'd0, bus.temp_valid}, 32'd0);
    check("abort data", {19'd0, bus.temp_data}, 32'd0);
    pulses = 0; frames = 0; pcs = bus.spi_cs_n;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (bus.temp_valid) pulses++;
      if (pcs && !bus.spi_cs_n) frames++;
      pcs = bus.spi_cs_n;
    end
    check("abort no valid", pulses, 0);
    check("abort no frame", frames, 0);

    for (int v = 0; v < 8; v++) begin
      sensor_word = vecs[v].frame;
      do_read(lat);
      check($sformatf("latency v%0d", v), lat, 165);
      check($sformatf("data v%0d", v), {19'd0, bus.temp_data}, {19'd0, vecs[v].exp_data});
      check($sformatf("fault v%0d", v), {31'd0, bus.sensor_fault}, {31'd0, vecs[v].exp_fault});
      check($sformatf("busy at valid v%0d", v), {31'd0, bus.busy}, 32'd0);
      @(negedge clk);
      check($sformatf("valid one cycle v%0d", v), {31'd0, bus.temp_valid}, 32'd0);
      repeat (4) @(negedge clk);
    end

    // start held every cycle for 400 cycles: reads do not queue or overlap.
    sensor_word = 16'h0C80;
    frames = 0; pulses = 0; rises = 0; r1 = -1; r2 = -1; f1 = -1; f2 = -1; n = 0;
    pcs = bus.spi_cs_n; psclk = bus.spi_sclk;
    for (int i = 0; i < 700; i++) begin
      bus.start = (i < 400);
      @(negedge clk);
      n++;
      if (pcs && !bus.spi_cs_n) begin
        frames++;
        if (f1 < 0) f1 = n;
        else if (f2 < 0) f2 = n;
      end
      if (!psclk && bus.spi_sclk) begin
        rises++;
        if (r1 < 0) r1 = n;
        else if (r2 < 0) r2 = n;
      end
      if (bus.temp_valid) pulses++;
      pcs = bus.spi_cs_n;
      psclk = bus.spi_sclk;
    end
    bus.start = 1'b0;
    check("held frames", frames, 3);
    check("held valids", pulses, 3);
    check("held sclk rises", rises, 48);
    check("sclk period", r2 - r1, 10);
    check("back-to-back spacing", f2 - f1, 166);
    check("held end busy", {31'd0, bus.busy}, 32'd0);
    check("held data", {19'd0, bus.temp_data}, 32'h190);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
